// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_ctrl
//  Description : Multi-cycle multiply/divide sequencer owning the MIPS HI/LO
//                register pair. Radix-2 shift-add multiply and restoring
//                divide, one step per cycle (32 steps), followed by a sign
//                fix-up/commit cycle. Stalls the front end while busy.
//  Ports       : Clk        - rising-edge clock
//                Rst        - asynchronous active-low reset
//                Start      - HI/LO op valid in EX
//                Op[2:0]    - 0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO
//                             6 MADD 7 MSUB
//                A[31:0]    - rs (multiplicand / dividend / MT source)
//                B[31:0]    - rt (multiplier / divisor)
//                MfRead     - MFHI/MFLO in ID this cycle
//                Cancel     - pipeline flush, abort in-flight op
//                Hi, Lo     - architectural HI/LO
//                Busy       - sequencer not idle
//                Stall      - Busy & (MfRead | Start)
//                Done       - one-cycle pulse after a mult/div commit
//                DivByZero  - pulses with Done for a divide by zero
//  Config      : define MULDIV_MADD_EN to enable MADD/MSUB (ops 6/7);
//                otherwise ops 6/7 are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MfRead,
    input  logic        Cancel,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic        DivByZero
);

    localparam logic [2:0] C_OP_MULT  = 3'd0;
    localparam logic [2:0] C_OP_MULTU = 3'd1;
    localparam logic [2:0] C_OP_DIV   = 3'd2;
    localparam logic [2:0] C_OP_DIVU  = 3'd3;
    localparam logic [2:0] C_OP_MTHI  = 3'd4;
    localparam logic [2:0] C_OP_MTLO  = 3'd5;
`ifdef MULDIV_MADD_EN
    localparam logic [2:0] C_OP_MADD  = 3'd6;
    localparam logic [2:0] C_OP_MSUB  = 3'd7;
`endif
    localparam logic [4:0] C_LAST_STEP = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_divByZero;
    // Multiplicand magnitude for MUL, divisor magnitude for DIV.
    logic [31:0] r_opB;
    // MUL: {partial product, remaining multiplier bits}
    // DIV: {partial remainder, dividend bits / quotient bits}
    logic [63:0] r_acc;
    logic        r_isDiv;
    logic        r_negRes;   // negate product, or quotient
    logic        r_negRem;   // negate remainder
    logic        r_divZero;
`ifdef MULDIV_MADD_EN
    logic        r_accum;    // accumulate product into {Hi,Lo}
    logic        r_accSub;   // subtract instead of add
`endif

    logic        w_isSigned;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [32:0] w_mulSum;
    logic [63:0] w_mulNext;
    logic [32:0] w_divTrial;
    logic [63:0] w_divNext;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_hiLoNext;

    // Signed ops iterate on operand magnitudes; signs are restored in FIX.
`ifdef MULDIV_MADD_EN
    assign w_isSigned = (Op == C_OP_MULT) || (Op == C_OP_DIV) ||
                        (Op == C_OP_MADD) || (Op == C_OP_MSUB);
`else
    assign w_isSigned = (Op == C_OP_MULT) || (Op == C_OP_DIV);
`endif
    assign w_magA = (w_isSigned && A[31]) ? (32'd0 - A) : A;
    assign w_magB = (w_isSigned && B[31]) ? (32'd0 - B) : B;

    // Shift-add: add multiplicand to the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    assign w_mulSum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opB} : 33'd0);
    assign w_mulNext = {w_mulSum, r_acc[31:1]};

    // Restoring step: shift remainder left with the next dividend bit and
    // try subtracting the divisor. A zero divisor always "succeeds", which
    // yields an all-ones quotient and the dividend as remainder.
    assign w_divTrial = r_acc[63:31] - {1'b0, r_opB};
    assign w_divNext  = w_divTrial[32] ? {r_acc[62:0], 1'b0}
                                       : {w_divTrial[31:0], r_acc[30:0], 1'b1};

    assign w_prod = r_negRes ? (64'd0 - r_acc) : r_acc;
    assign w_quot = r_negRes ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
    assign w_rem  = r_negRem ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

`ifdef MULDIV_MADD_EN
    assign w_hiLoNext = !r_accum ? w_prod :
                        r_accSub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
`else
    assign w_hiLoNext = w_prod;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= S_IDLE;
            r_count     <= 5'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_done      <= 1'b0;
            r_divByZero <= 1'b0;
            r_opB       <= 32'd0;
            r_acc       <= 64'd0;
            r_isDiv     <= 1'b0;
            r_negRes    <= 1'b0;
            r_negRem    <= 1'b0;
            r_divZero   <= 1'b0;
`ifdef MULDIV_MADD_EN
            r_accum     <= 1'b0;
            r_accSub    <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_divByZero <= 1'b0;
            if (Cancel) begin
                // Flush wins over commit and over a new Start.
                r_state <= S_IDLE;
                r_count <= 5'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (Start) begin
                            r_count <= 5'd0;
                            case (Op)
                                C_OP_MTHI: r_hi <= A;
                                C_OP_MTLO: r_lo <= A;
`ifdef MULDIV_MADD_EN
                                C_OP_MULT, C_OP_MULTU, C_OP_MADD, C_OP_MSUB: begin
`else
                                C_OP_MULT, C_OP_MULTU: begin
`endif
                                    r_opB    <= w_magA;
                                    r_acc    <= {32'd0, w_magB};
                                    r_negRes <= w_isSigned & (A[31] ^ B[31]);
                                    r_negRem <= 1'b0;
                                    r_isDiv  <= 1'b0;
`ifdef MULDIV_MADD_EN
                                    r_accum  <= (Op == C_OP_MADD) || (Op == C_OP_MSUB);
                                    r_accSub <= (Op == C_OP_MSUB);
`endif
                                    r_state  <= S_MUL;
                                end
                                C_OP_DIV, C_OP_DIVU: begin
                                    r_opB     <= w_magB;
                                    r_acc     <= {32'd0, w_magA};
                                    r_negRes  <= w_isSigned & (A[31] ^ B[31]);
                                    r_negRem  <= w_isSigned & A[31];
                                    r_divZero <= (B == 32'd0);
                                    r_isDiv   <= 1'b1;
`ifdef MULDIV_MADD_EN
                                    r_accum   <= 1'b0;
                                    r_accSub  <= 1'b0;
`endif
                                    r_state   <= S_DIV;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        r_acc   <= w_mulNext;
                        r_count <= r_count + 5'd1;
                        if (r_count == C_LAST_STEP) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_DIV: begin
                        r_acc   <= w_divNext;
                        r_count <= r_count + 5'd1;
                        if (r_count == C_LAST_STEP) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (r_isDiv) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_hiLoNext[63:32];
                            r_lo <= w_hiLoNext[31:0];
                        end
                        r_done      <= 1'b1;
                        r_divByZero <= r_isDiv & r_divZero;
                        r_count     <= 5'd0;
                        r_state     <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign Hi        = r_hi;
    assign Lo        = r_lo;
    assign Busy      = (r_state != S_IDLE);
    assign Stall     = Busy & (MfRead | Start);
    assign Done      = r_done;
    assign DivByZero = r_divByZero;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_muldiv_ctrl
//  Description : Self-checking bench for hilo_muldiv_ctrl. Expected HI/LO
//                results are queued when an op is issued and compared when
//                Done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_ctrl;

    localparam logic [2:0] C_MULT  = 3'd0;
    localparam logic [2:0] C_MULTU = 3'd1;
    localparam logic [2:0] C_DIV   = 3'd2;
    localparam logic [2:0] C_DIVU  = 3'd3;
    localparam logic [2:0] C_MTHI  = 3'd4;
    localparam logic [2:0] C_MTLO  = 3'd5;
    localparam logic [2:0] C_MADD  = 3'd6;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        MfRead;
    logic        Cancel;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic        DivByZero;

    exp_t sb[$];
    int   nCompared;
    int   nMismatch;

    hilo_muldiv_ctrl dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .MfRead    (MfRead),
        .Cancel    (Cancel),
        .Hi        (Hi),
        .Lo        (Lo),
        .Busy      (Busy),
        .Stall     (Stall),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Present an op at the current negedge; sampled at the next posedge.
    task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
    endtask

    task automatic mt_write(input logic [2:0] op, input logic [31:0] a);
        drive_start(op, a, 32'd0);
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Returns the negedge index at which Done was seen, or -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge Clk);
            if (n == 1) Start = 1'b0;
            if (Done === 1'b1) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
        MfRead = 1'b0; Cancel = 1'b0;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        nCompared++;
        if ({Hi, Lo, Busy, Stall, Done, DivByZero} !== {64'd0, 4'b0000}) begin
            nMismatch++;
            $display("FAIL reset_values: got Hi=%h Lo=%h Busy=%b Stall=%b Done=%b Dbz=%b, expected all zero",
                     Hi, Lo, Busy, Stall, Done, DivByZero);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        mt_write(C_MTHI, 32'd55);
        nCompared++;
        if (Hi !== 32'd55) begin
            nMismatch++;
            $display("FAIL mthi_write: got Hi=%h expected %h", Hi, 32'd55);
        end
        drive_start(C_MULT, 32'd7, 32'd9);
        for (int n = 1; n <= 10; n++) begin
            @(negedge Clk);
            if (n == 1) Start = 1'b0;
        end
        Rst = 1'b0;
        #1;
        nCompared++;
        if ({Busy, Hi, Lo, Done} !== {1'b0, 64'd0, 1'b0}) begin
            nMismatch++;
            $display("FAIL reset_mid_mul: got Busy=%b Hi=%h Lo=%h Done=%b, expected 0/0/0/0", Busy, Hi, Lo, Done);
        end
        @(negedge Clk);
        Rst = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done !== 1'b0 || Busy !== 1'b0) bad++;
        end
        nCompared++;
        if (bad != 0) begin
            nMismatch++;
            $display("FAIL reset_no_done: got %0d cycles with Done/Busy set, expected 0", bad);
        end
    endtask

    task automatic test_mult();
        int   cyc;
        exp_t e;
        sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF1, dbz: 1'b0});
        drive_start(C_MULT, 32'hFFFFFFFD, 32'd5);
        wait_done(cyc);
        nCompared++;
        if (cyc != 34) begin
            nMismatch++;
            $display("FAIL mult_latency: got Done at cycle %0d, expected 34", cyc);
        end
        e = sb.pop_front();
        nCompared++;
        if ({Hi, Lo, DivByZero} !== {e.hi, e.lo, e.dbz}) begin
            nMismatch++;
            $display("FAIL mult_result: got %h_%h dbz=%b, expected %h_%h dbz=%b", Hi, Lo, DivByZero, e.hi, e.lo, e.dbz);
        end
        @(negedge Clk);
        nCompared++;
        if (Done !== 1'b0) begin
            nMismatch++;
            $display("FAIL done_one_cycle: got Done=%b on following cycle, expected 0", Done);
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [3] = '{C_DIV, C_DIVU, C_DIV};
        logic [31:0] as  [3] = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] bs  [3] = '{32'd2, 32'd0, 32'hFFFFFFFF};
        exp_t        es  [3] = '{'{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, dbz: 1'b0},
                                 '{hi: 32'd7,        lo: 32'hFFFFFFFF, dbz: 1'b1},
                                 '{hi: 32'd0,        lo: 32'h80000000, dbz: 1'b0}};
        int   cyc;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(es[i]);
            drive_start(ops[i], as[i], bs[i]);
            wait_done(cyc);
            e = sb.pop_front();
            nCompared++;
            if (cyc != 34 || {Hi, Lo, DivByZero} !== {e.hi, e.lo, e.dbz}) begin
                nMismatch++;
                $display("FAIL div_case%0d: got cyc=%0d Hi=%h Lo=%h dbz=%b, expected cyc=34 Hi=%h Lo=%h dbz=%b",
                         i, cyc, Hi, Lo, DivByZero, e.hi, e.lo, e.dbz);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        exp_t e;
        sb.push_back('{hi: 32'hFFFFFFFE, lo: 32'h00000001, dbz: 1'b0});
        drive_start(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc);
        e = sb.pop_front();
        nCompared++;
        if (cyc != 34 || {Hi, Lo} !== {e.hi, e.lo}) begin
            nMismatch++;
            $display("FAIL multu_result: got cyc=%0d %h_%h, expected cyc=34 %h_%h", cyc, Hi, Lo, e.hi, e.lo);
        end
        // MTLO issued in the Done cycle.
        drive_start(C_MTLO, 32'd1234, 32'd0);
        @(negedge Clk);
        Start = 1'b0;
        nCompared++;
        if ({Hi, Lo, Busy} !== {32'hFFFFFFFE, 32'd1234, 1'b0}) begin
            nMismatch++;
            $display("FAIL mtlo_after_done: got Hi=%h Lo=%h Busy=%b, expected FFFFFFFE/%h/0", Hi, Lo, Busy, 32'd1234);
        end
    endtask

    task automatic test_stall();
        int   cyc;
        int   bad;
        exp_t e;
        cyc = -1;
        bad = 0;
        sb.push_back('{hi: 32'd2, lo: 32'd14, dbz: 1'b0});
        drive_start(C_DIVU, 32'd100, 32'd7);
        for (int n = 1; n <= 60; n++) begin
            @(negedge Clk);
            if (n == 1) begin
                Start = 1'b0;
                nCompared++;
                if (Busy !== 1'b1) begin
                    nMismatch++;
                    $display("FAIL busy_after_start: got Busy=%b, expected 1", Busy);
                end
            end
            if (n == 3) begin
                drive_start(C_MTHI, 32'd999, 32'd0);
                #1;
                nCompared++;
                if (Stall !== 1'b1) begin
                    nMismatch++;
                    $display("FAIL stall_on_start: got Stall=%b, expected 1", Stall);
                end
            end
            if (n == 4) Start = 1'b0;
            if (n == 5) MfRead = 1'b1;
            if (Done === 1'b1) begin
                cyc = n;
                break;
            end
            if (n >= 5) begin
                #1;
                if (Stall !== 1'b1) bad++;
            end
        end
        nCompared++;
        if (bad != 0) begin
            nMismatch++;
            $display("FAIL stall_hold: got %0d cycles with Stall low, expected 0", bad);
        end
        nCompared++;
        if (cyc != 34 || Stall !== 1'b0) begin
            nMismatch++;
            $display("FAIL stall_release: got cyc=%0d Stall=%b, expected cyc=34 Stall=0", cyc, Stall);
        end
        e = sb.pop_front();
        nCompared++;
        if ({Hi, Lo} !== {e.hi, e.lo}) begin
            nMismatch++;
            $display("FAIL divu_ignored_start: got Hi=%h Lo=%h, expected Hi=%h Lo=%h", Hi, Lo, e.hi, e.lo);
        end
        MfRead = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_cancel();
        int bad;
        mt_write(C_MTHI, 32'h0000AAAA);
        mt_write(C_MTLO, 32'h00005555);
        drive_start(C_MULT, 32'd3, 32'd4);
        for (int n = 1; n <= 33; n++) begin
            @(negedge Clk);
            if (n == 1) Start = 1'b0;
        end
        nCompared++;
        if (Busy !== 1'b1) begin
            nMismatch++;
            $display("FAIL cancel_fix_busy: got Busy=%b in FIX cycle, expected 1", Busy);
        end
        Cancel = 1'b1;
        @(negedge Clk);
        Cancel = 1'b0;
        nCompared++;
        if ({Busy, Done, Hi, Lo} !== {1'b0, 1'b0, 32'h0000AAAA, 32'h00005555}) begin
            nMismatch++;
            $display("FAIL cancel_fix: got Busy=%b Done=%b Hi=%h Lo=%h, expected 0/0/0000aaaa/00005555",
                     Busy, Done, Hi, Lo);
        end
        bad = 0;
        repeat (3) begin
            @(negedge Clk);
            if (Done !== 1'b0) bad++;
        end
        nCompared++;
        if (bad != 0) begin
            nMismatch++;
            $display("FAIL cancel_no_done: got %0d Done pulses, expected 0", bad);
        end
    endtask

    task automatic test_madd();
`ifdef MULDIV_MADD_EN
        int   cyc;
        exp_t e;
        mt_write(C_MTHI, 32'd0);
        mt_write(C_MTLO, 32'd10);
        sb.push_back('{hi: 32'd0, lo: 32'd16, dbz: 1'b0});
        drive_start(C_MADD, 32'd2, 32'd3);
        wait_done(cyc);
        e = sb.pop_front();
        nCompared++;
        if (cyc != 34 || {Hi, Lo} !== {e.hi, e.lo}) begin
            nMismatch++;
            $display("FAIL madd_result: got cyc=%0d Hi=%h Lo=%h, expected cyc=34 Hi=%h Lo=%h", cyc, Hi, Lo, e.hi, e.lo);
        end
        @(negedge Clk);
        sb.push_back('{hi: 32'd0, lo: 32'd10, dbz: 1'b0});
        drive_start(3'd7, 32'd2, 32'd3);
        wait_done(cyc);
        e = sb.pop_front();
        nCompared++;
        if (cyc != 34 || {Hi, Lo} !== {e.hi, e.lo}) begin
            nMismatch++;
            $display("FAIL msub_result: got cyc=%0d Hi=%h Lo=%h, expected cyc=34 Hi=%h Lo=%h", cyc, Hi, Lo, e.hi, e.lo);
        end
        @(negedge Clk);
`else
        int bad;
        mt_write(C_MTHI, 32'd0);
        mt_write(C_MTLO, 32'd10);
        drive_start(C_MADD, 32'd2, 32'd3);
        bad = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clk);
            if (n == 1) Start = 1'b0;
            if (Busy !== 1'b0 || Done !== 1'b0) bad++;
        end
        nCompared++;
        if (bad != 0) begin
            nMismatch++;
            $display("FAIL madd_noop_busy: got %0d cycles with Busy/Done set, expected 0", bad);
        end
        nCompared++;
        if ({Hi, Lo} !== {32'd0, 32'd10}) begin
            nMismatch++;
            $display("FAIL madd_noop_hilo: got Hi=%h Lo=%h, expected Hi=0 Lo=%h", Hi, Lo, 32'd10);
        end
`endif
    endtask

    initial begin
        nCompared = 0;
        nMismatch = 0;
        test_reset();
        test_reset_mid();
        test_mult();
        test_div();
        test_back_to_back();
        test_stall();
        test_cancel();
        test_madd();
        nCompared++;
        if (sb.size() != 0) begin
            nMismatch++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair of the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, iterates radix-2 shift-add multiply or restoring divide, and commits results to HI/LO. It stalls the front end when an MFHI/MFLO read or a new HI/LO op arrives while an operation is in flight. Decode of the funct field into `Op` happens upstream in the control unit.

## Interface
- No parameters; datapath width fixed at 32.
- `Clk` in 1: rising-edge clock.
- `Rst` in 1: asynchronous, active-low reset.
- `Start` in 1: valid HI/LO op in EX this cycle.
- `Op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- `A` in 32: rs value (multiplicand/dividend/MT source).
- `B` in 32: rt value (multiplier/divisor).
- `MfRead` in 1: ID holds MFHI/MFLO this cycle.
- `Cancel` in 1: pipeline flush; abort in-flight op.
- `Hi` out 32, `Lo` out 32: architectural HI/LO.
- `Busy` out 1: state != IDLE.
- `Stall` out 1: `Busy & (MfRead | Start)`.
- `Done` out 1: one-cycle pulse after HI/LO commit of a mult/div.
- `DivByZero` out 1: pulses with `Done` when a divide had `B == 0`.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + `Start`:
  - MTHI: `Hi <= A`.
  - MTLO: `Lo <= A`.
  - Both stay in IDLE, with no `Done`.
  - MULT/MULTU/MADD/MSUB: latch operands, go to MUL.
  - DIV/DIVU: latch operands, go to DIV.
  - Count is cleared to 0.
- Signed ops (MULT, DIV, MADD, MSUB) iterate on magnitudes. They record the result sign (mult: `A[31]^B[31]`) and the remainder sign (div: `A[31]`).
- MUL: 64-bit accumulator, one shift-add per cycle, 32 cycles, then FIX.
- DIV: restoring step per cycle, 32 cycles, then FIX.
- FIX: apply two's-complement negation where required.
  - Mult: negate the 64-bit product if the sign flag is set.
  - Div: negate the quotient if `A[31]^B[31]`; negate the remainder if `A[31]`.
  - Write `{Hi,Lo}` = product, or `Hi` = remainder, `Lo` = quotient.
  - Go to IDLE; `Done` = 1 the following cycle.
- Divide-by-zero: the iteration still runs. Result is `Lo = 32'hFFFFFFFF`, `Hi = A` (unsigned) or sign-fixed equivalents, and `DivByZero` pulses.
- `0x80000000 / -1` (DIV): `Lo = 32'h80000000`, `Hi = 0`.
- `Start` while `Busy`: ignored; `Stall` is held so EX re-presents it.
- `Cancel`: any state goes to IDLE next edge. HI/LO are not written and `Done` does not pulse. `Cancel` has priority over FIX commit and over `Start`.
- Reset mid-operation: all state cleared immediately; no commit.

## Timing
- Reset values: `Hi = 0`, `Lo = 0`, `Busy = 0`, `Stall = 0`, `Done = 0`, `DivByZero = 0`, state IDLE, count 0.
- MTHI/MTLO: `Hi`/`Lo` visible the cycle after the `Start` edge.
- Mult/div sequence:
  - Edge 0 samples `Start`.
  - `Busy` is high from the cycle after edge 0.
  - Edges 1–32 iterate.
  - Edge 33 (FIX) commits; `Hi`/`Lo` are valid and `Busy` = 0 from then.
  - `Done` is high for the single cycle after edge 33.
- Latency: 34 cycles from the `Start` edge to the committed result.
- `Stall` is combinational from `Busy`, `MfRead` and `Start`; it has no registered delay.
- A new `Start` is accepted in the same cycle `Done` is high (back-to-back).

## Configuration
- `MULDIV_MADD_EN` defined:
  - Op 6 (MADD) adds the signed product to `{Hi,Lo}` at FIX.
  - Op 7 (MSUB) subtracts it.
  - Latency is unchanged.
- `MULDIV_MADD_EN` undefined:
  - Ops 6 and 7 are treated as no-ops: no state change, no `Busy`, `Hi`/`Lo` untouched.
  - No 64-bit accumulate adder is synthesized.

## Test plan
- Reset low mid-MUL at cycle 10 → `Busy = 0`, `Hi = Lo = 0` immediately; no `Done`.
- MULT `A = -3`, `B = 5` → after 34 cycles `Hi = FFFFFFFF`, `Lo = FFFFFFF1`, one-cycle `Done`.
- DIV `A = -7`, `B = 2` → `Lo = FFFFFFFD`, `Hi = FFFFFFFF`. DIVU `A = 7`, `B = 0` → `Lo = FFFFFFFF`, `Hi = 7`, `DivByZero = 1` with `Done`.
- MULTU `FFFFFFFF × FFFFFFFF` → `Hi = FFFFFFFE`, `Lo = 00000001`. Then MTLO `A = 1234` in the `Done` cycle → `Lo = 1234` next cycle.
- `MfRead = 1` at cycle 5 of DIV → `Stall = 1` through edge 33, `Stall = 0` in the `Done` cycle. `Start` during `Busy` → ignored, `Stall = 1`.
- `Cancel` in FIX cycle → `Hi`/`Lo` keep prior values, no `Done`. With `MULDIV_MADD_EN` and `{Hi,Lo} = 10`, MADD `2 × 3` → `Lo = 16`; without it → `Lo = 10`, `Busy` never asserts.
